// File: rtl/pipe_ctrl_if.sv
// Pipeline-controller bus: per-stage hold requests, exception commit, and
// the stall/flush/diagnostic outputs returned to the datapath.
interface pipe_ctrl_if;
  logic        STALLREQ_ID;
  logic        STALLREQ_EX;
  logic        STALLREQ_MEM;
  logic        EXCEPT_REQ;
  logic [31:0] EXCEPT_PC;
  logic [5:0]  STALL;
  logic        FLUSH;
  logic [31:0] NEW_PC;
  logic        WDOG_ERR;
  logic [31:0] PERF_STALL_CNT;

  // Datapath side: raises requests, consumes controls.
  modport master (
    output STALLREQ_ID, STALLREQ_EX, STALLREQ_MEM, EXCEPT_REQ, EXCEPT_PC,
    input  STALL, FLUSH, NEW_PC, WDOG_ERR, PERF_STALL_CNT
  );

  // Controller side.
  modport slave (
    input  STALLREQ_ID, STALLREQ_EX, STALLREQ_MEM, EXCEPT_REQ, EXCEPT_PC,
    output STALL, FLUSH, NEW_PC, WDOG_ERR, PERF_STALL_CNT
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall-vector merge, one-cycle exception flush,
// stall watchdog and stall-cycle performance counter.
module pipe_ctrl #(
  parameter int unsigned WDOG_LIMIT = 255,
  parameter int unsigned WDOG_W     = 8
) (
  input  logic         CLK,
  input  logic         RST,
  pipe_ctrl_if.slave   bus
);

  localparam int unsigned STALL_W = 6;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 32;

  localparam logic [STALL_W-1:0] HOLD_NONE = STALL_W'(6'b000000);
  localparam logic [STALL_W-1:0] HOLD_ID   = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] HOLD_EX   = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] HOLD_MEM  = STALL_W'(6'b011111);

  localparam logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}};
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_LIMIT);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [STALL_W-1:0] req_stall_c;
  logic [STALL_W-1:0] stall_c;
  logic               accept_c;
  logic               stalled_c;

  logic               flush_q;
  logic [PC_W-1:0]    new_pc_q;
  logic [WDOG_W-1:0]  wdog_cnt_q;
  logic [WDOG_W-1:0]  wdog_inc_c;
  logic               wdog_err_q;
  logic [CNT_W-1:0]   perf_cnt_q;

  // Highest requesting stage wins; WB (bit5) is never held.
  always_comb begin
    req_stall_c = HOLD_NONE;
    if (bus.STALLREQ_MEM) begin
      req_stall_c = HOLD_MEM;
    end else if (bus.STALLREQ_EX) begin
      req_stall_c = HOLD_EX;
    end else if (bus.STALLREQ_ID) begin
      req_stall_c = HOLD_ID;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and combinational stall output; reset forces STALL low.
  always_comb begin
    state_d  = state_q;
    stall_c  = HOLD_NONE;
    accept_c = 1'b0;
    if (!RST) begin
      case (state_q)
        ST_RUN: begin
          stall_c = req_stall_c;
          if (bus.EXCEPT_REQ) begin
            accept_c = 1'b1;
            state_d  = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign stalled_c  = |stall_c;
  assign wdog_inc_c = (wdog_cnt_q == WDOG_MAX) ? WDOG_MAX : wdog_cnt_q + WDOG_W'(1);

  // Flush pulse and handler PC capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      flush_q <= accept_c;
      if (accept_c) begin
        new_pc_q <= bus.EXCEPT_PC;
      end
    end
  end

  // Watchdog: consecutive stalled RUN cycles; entering FLUSH restarts it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else if (accept_c || !stalled_c) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_inc_c;
      if (wdog_inc_c == WDOG_LIM) begin
        wdog_err_q <= 1'b1;
      end
    end
  end

  // Free-running stall-cycle count, wraps modulo 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_cnt_q <= '0;
    end else if (stalled_c) begin
      perf_cnt_q <= perf_cnt_q + CNT_W'(1);
    end
  end

  assign bus.STALL          = stall_c;
  assign bus.FLUSH          = flush_q;
  assign bus.NEW_PC         = new_pc_q;
  assign bus.WDOG_ERR       = wdog_err_q;
  assign bus.PERF_STALL_CNT = perf_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vectors, a cycle-level reference model checked
// every negedge, plus literal spot checks.
module tb_pipe_ctrl;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned WW    = 8;

  logic CLK = 1'b0;
  logic RST;
  pipe_ctrl_if bus ();

  pipe_ctrl #(.WDOG_LIMIT(LIMIT), .WDOG_W(WW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  bit          m_flush = 1'b0;
  logic [31:0] m_pc    = '0;
  int          m_run   = 0;
  bit          m_err   = 1'b0;
  logic [31:0] m_perf  = '0;

  function automatic logic [5:0] exp_stall();
    int top;
    logic [5:0] mask;
    top = -1;
    if (bus.STALLREQ_ID)  top = 2;
    if (bus.STALLREQ_EX)  top = 3;
    if (bus.STALLREQ_MEM) top = 4;
    if (RST || m_flush || top < 0) mask = 6'd0;
    else mask = 6'((1 << (top + 1)) - 1);
    return mask;
  endfunction

  always @(posedge CLK) begin
    logic [5:0] s;
    bit acc;
    s = exp_stall();
    if (RST) begin
      m_flush = 1'b0; m_pc = '0; m_run = 0; m_err = 1'b0; m_perf = '0;
      m_valid = 1'b1;
    end else begin
      acc = !m_flush && bus.EXCEPT_REQ;
      if (s != 0) m_perf = m_perf + 32'd1;
      if (acc) m_pc = bus.EXCEPT_PC;
      if (s != 0 && !acc) begin
        if (m_run < (2 ** WW) - 1) m_run = m_run + 1;
        if (m_run == LIMIT) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
      m_flush = acc;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_stall", 32'(bus.STALL), 32'(exp_stall()));
      chk("model_flush", 32'(bus.FLUSH), 32'(m_flush));
      chk("model_new_pc", bus.NEW_PC, m_pc);
      chk("model_wdog_err", 32'(bus.WDOG_ERR), 32'(m_err));
      chk("model_perf", bus.PERF_STALL_CNT, m_perf);
    end
  end

  // One clock: inputs change 1 time unit after the edge, checks follow at +3.
  task automatic cyc(input bit rst, input bit id, input bit ex, input bit mem,
                     input bit xr, input logic [31:0] pc);
    @(posedge CLK);
    #1;
    RST              = rst;
    bus.STALLREQ_ID  = id;
    bus.STALLREQ_EX  = ex;
    bus.STALLREQ_MEM = mem;
    bus.EXCEPT_REQ   = xr;
    bus.EXCEPT_PC    = pc;
    #2;
  endtask

  initial begin
    RST = 1'b1;
    bus.STALLREQ_ID = 1'b0; bus.STALLREQ_EX = 1'b0; bus.STALLREQ_MEM = 1'b1;
    bus.EXCEPT_REQ = 1'b0;  bus.EXCEPT_PC = '0;

    // Reset with MEM hold asserted
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("rst_stall", 32'(bus.STALL), 32'h0);
    chk("rst_flush", 32'(bus.FLUSH), 32'h0);
    chk("rst_new_pc", bus.NEW_PC, 32'h0);
    chk("rst_perf", bus.PERF_STALL_CNT, 32'h0);
    chk("rst_wdog", 32'(bus.WDOG_ERR), 32'h0);
    cyc(0, 0, 0, 0, 0, 0);

    // Priority decode
    cyc(0, 1, 0, 0, 0, 0); chk("dec_id", 32'(bus.STALL), 32'h07);
    cyc(0, 1, 1, 0, 0, 0); chk("dec_ex", 32'(bus.STALL), 32'h0F);
    cyc(0, 1, 1, 1, 0, 0); chk("dec_mem", 32'(bus.STALL), 32'h1F);
    cyc(0, 0, 0, 0, 0, 0); chk("dec_none", 32'(bus.STALL), 32'h00);
    chk("dec_perf", bus.PERF_STALL_CNT, 32'd3);

    // Flush sequencing with EX hold in the accept cycle
    cyc(0, 0, 1, 0, 1, 32'hBFC00380); chk("fl_acc_stall", 32'(bus.STALL), 32'h0F);
    cyc(0, 0, 1, 0, 0, 0);
    chk("fl_pulse", 32'(bus.FLUSH), 32'h1);
    chk("fl_pc", bus.NEW_PC, 32'hBFC00380);
    chk("fl_stall0", 32'(bus.STALL), 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("fl_end", 32'(bus.FLUSH), 32'h0);
    chk("fl_pc_hold", bus.NEW_PC, 32'hBFC00380);

    // Request held through FLUSH is dropped, then re-accepted in RUN
    cyc(0, 0, 0, 0, 1, 32'h80000180);
    cyc(0, 0, 0, 0, 1, 32'h80000200);
    chk("b2b_p1", 32'(bus.FLUSH), 32'h1);
    chk("b2b_pc1", bus.NEW_PC, 32'h80000180);
    cyc(0, 0, 0, 0, 1, 32'h80000300);
    chk("b2b_gap", 32'(bus.FLUSH), 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("b2b_p2", 32'(bus.FLUSH), 32'h1);
    chk("b2b_pc2", bus.NEW_PC, 32'h80000300);
    cyc(0, 0, 0, 0, 0, 0);
    chk("b2b_end", 32'(bus.FLUSH), 32'h0);

    // Watchdog: 3 stalls then release, then 4 consecutive
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); chk("wd_three", 32'(bus.WDOG_ERR), 32'h0);
    repeat (4) cyc(0, 0, 0, 1, 0, 0);
    chk("wd_before4", 32'(bus.WDOG_ERR), 32'h0);
    cyc(0, 0, 0, 0, 0, 0); chk("wd_four", 32'(bus.WDOG_ERR), 32'h1);
    cyc(0, 0, 0, 0, 0, 0); chk("wd_sticky", 32'(bus.WDOG_ERR), 32'h1);

    // Reset coincident with an exception request leaves no pulse
    cyc(1, 0, 0, 0, 1, 32'h12345678);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rx_flush", 32'(bus.FLUSH), 32'h0);
    chk("rx_pc", bus.NEW_PC, 32'h0);
    chk("rx_wdog", 32'(bus.WDOG_ERR), 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rx_no_pulse", 32'(bus.FLUSH), 32'h0);

    // Perf counter across a flush: 5 + 5 stalled cycles
    repeat (5) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h00000400);
    cyc(0, 0, 0, 0, 0, 0); chk("pf_flush", 32'(bus.FLUSH), 32'h1);
    repeat (5) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); chk("pf_ten", bus.PERF_STALL_CNT, 32'd10);

    // Wrap from all-ones
    force dut.perf_cnt_q = 32'hFFFFFFFF;
    m_perf = 32'hFFFFFFFF;
    @(posedge CLK);
    #1;
    release dut.perf_cnt_q;
    bus.STALLREQ_EX = 1'b1;
    #2;
    chk("pf_max", bus.PERF_STALL_CNT, 32'hFFFFFFFF);
    cyc(0, 0, 0, 0, 0, 0); chk("pf_wrap", bus.PERF_STALL_CNT, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);

    @(posedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
